alu_request_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one 32-bit ALU between requesters A and B. It accepts operation requests over valid/ready handshakes, grants the ALU round-robin, and holds operands and command stable for a configurable settle time. It then captures result, carryout, zero and overflow into registers and returns them over a per-requester response handshake. It sits between the instruction-side controllers and the combinational ALU and its zero-detect stage.

---
 rtl/alu_request_arbiter.sv | 167 ++++++++++++++++
 tb/tb_alu_request_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_request_arbiter.sv
// Two-port round-robin arbiter/sequencer sharing one combinational 32-bit ALU.
// Optional zero-flag cross-check enabled by defining ALU_ARB_ZERO_CHECK_EN.
package alu_request_arbiter_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 3;

  typedef struct packed {
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [CMD_W-1:0]  cmd;
  } alu_req_t;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              carryout;
    logic              zero;
    logic              overflow;
  } alu_rsp_t;
endpackage

module alu_request_arbiter
  import alu_request_arbiter_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid_a,
  input  logic              req_valid_b,
  output logic              req_ready_a,
  output logic              req_ready_b,
  input  logic [DATA_W-1:0] req_opa_a,
  input  logic [DATA_W-1:0] req_opb_a,
  input  logic [DATA_W-1:0] req_opa_b,
  input  logic [DATA_W-1:0] req_opb_b,
  input  logic [CMD_W-1:0]  req_cmd_a,
  input  logic [CMD_W-1:0]  req_cmd_b,
  output logic              rsp_valid_a,
  output logic              rsp_valid_b,
  input  logic              rsp_ready_a,
  input  logic              rsp_ready_b,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_carryout,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic [DATA_W-1:0] alu_opa,
  output logic [DATA_W-1:0] alu_opb,
  output logic [CMD_W-1:0]  alu_cmd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carryout,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              zero_err
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t     state, state_nxt;
  logic       prio;   // 0 = A has priority, 1 = B
  logic       owner;  // 0 = A owns the in-flight op, 1 = B
  logic [CNT_W-1:0] cnt;
  alu_req_t   op_q;
  alu_rsp_t   rsp_q;
  alu_req_t   req_a_c, req_b_c;
  logic       grant_a_c, grant_b_c, capture_c, done_c;

  assign req_a_c = '{opa: req_opa_a, opb: req_opb_a, cmd: req_cmd_a};
  assign req_b_c = '{opa: req_opa_b, opb: req_opb_b, cmd: req_cmd_b};

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Arbitration and sequencing
  always_comb begin
    state_nxt = state;
    grant_a_c = 1'b0;
    grant_b_c = 1'b0;
    capture_c = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_a && (!req_valid_b || !prio)) grant_a_c = 1'b1;
        else if (req_valid_b)                        grant_b_c = 1'b1;
        if (grant_a_c || grant_b_c) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) begin
          capture_c = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (owner ? rsp_ready_b : rsp_ready_a) begin
          done_c    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ready is forced low while reset is asserted so all outputs read 0
  assign req_ready_a = grant_a_c & reset_n;
  assign req_ready_b = grant_b_c & reset_n;

  // Operand latch, latency counter, response capture, round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio        <= 1'b0;
      owner       <= 1'b0;
      cnt         <= '0;
      op_q        <= '0;
      rsp_q       <= '0;
      rsp_valid_a <= 1'b0;
      rsp_valid_b <= 1'b0;
    end else begin
      if (grant_a_c || grant_b_c) begin
        op_q  <= grant_b_c ? req_b_c : req_a_c;
        owner <= grant_b_c;
        cnt   <= CNT_W'(ALU_LATENCY);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (capture_c) begin
        rsp_q       <= '{result: alu_result, carryout: alu_carryout,
                         zero: alu_zero, overflow: alu_overflow};
        rsp_valid_a <= ~owner;
        rsp_valid_b <= owner;
      end
      if (done_c) begin
        rsp_valid_a <= 1'b0;
        rsp_valid_b <= 1'b0;
        prio        <= ~owner;
      end
    end
  end

  assign alu_opa      = op_q.opa;
  assign alu_opb      = op_q.opb;
  assign alu_cmd      = op_q.cmd;
  assign rsp_result   = rsp_q.result;
  assign rsp_carryout = rsp_q.carryout;
  assign rsp_zero     = rsp_q.zero;
  assign rsp_overflow = rsp_q.overflow;

`ifdef ALU_ARB_ZERO_CHECK_EN
  logic zero_err_q;

  // Sticky flag: ALU zero output disagrees with its own result at capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      zero_err_q <= 1'b0;
    else if (capture_c && ((alu_result == '0) != alu_zero))
      zero_err_q <= 1'b1;
  end

  assign zero_err = zero_err_q;
`else
  assign zero_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_request_arbiter.sv
// Directed self-checking bench for alu_request_arbiter (latency 1 and 3 instances).
module tb_alu_request_arbiter;

  localparam logic [2:0] C_ADD = 3'd0, C_SUB = 3'd1, C_XOR = 3'd2, C_SLT = 3'd3,
                         C_AND = 3'd4, C_NAND = 3'd5, C_NOR = 3'd6, C_OR = 3'd7;
`ifdef ALU_ARB_ZERO_CHECK_EN
  localparam logic ZERR_EXP = 1'b1;
`else
  localparam logic ZERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic [31:0] req_opa_a = '0, req_opb_a = '0, req_opa_b = '0, req_opb_b = '0;
  logic [2:0] req_cmd_a = '0, req_cmd_b = '0;
  logic rsp_ready_a = 1'b0, rsp_ready_b = 1'b0;
  logic force_bad = 1'b0;

  logic req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b;
  logic [31:0] rsp_result, alu_opa, alu_opb, alu_result;
  logic rsp_carryout, rsp_zero, rsp_overflow, zero_err;
  logic alu_carryout, alu_zero, alu_overflow;
  logic [2:0] alu_cmd;

  logic req_ready_a3, req_ready_b3, rsp_valid_a3, rsp_valid_b3;
  logic [31:0] rsp_result3, alu_opa3, alu_opb3, alu_result3;
  logic rsp_carryout3, rsp_zero3, rsp_overflow3, zero_err3;
  logic alu_carryout3, alu_zero3, alu_overflow3;
  logic [2:0] alu_cmd3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Reference ALU: {carryout, overflow, result}
  function automatic logic [33:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [2:0] cmd);
    logic [32:0] s;
    logic ov;
    s  = '0;
    ov = 1'b0;
    case (cmd)
      C_ADD: begin
        s  = {1'b0, a} + {1'b0, b};
        ov = (a[31] == b[31]) && (s[31] != a[31]);
      end
      C_SUB: begin
        s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
        ov = (a[31] != b[31]) && (s[31] != a[31]);
      end
      C_XOR:  s = {1'b0, a ^ b};
      C_SLT:  s = {1'b0, 31'd0, ($signed(a) < $signed(b))};
      C_AND:  s = {1'b0, a & b};
      C_NAND: s = {1'b0, ~(a & b)};
      C_NOR:  s = {1'b0, ~(a | b)};
      default: s = {1'b0, a | b};
    endcase
    return {s[32], ov, s[31:0]};
  endfunction

  assign {alu_carryout, alu_overflow, alu_result} = alu_f(alu_opa, alu_opb, alu_cmd);
  assign alu_zero = force_bad ? 1'b0 : (alu_result == 32'd0);
  assign {alu_carryout3, alu_overflow3, alu_result3} = alu_f(alu_opa3, alu_opb3, alu_cmd3);
  assign alu_zero3 = force_bad ? 1'b0 : (alu_result3 == 32'd0);

  alu_request_arbiter #(.ALU_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
    .req_ready_a(req_ready_a), .req_ready_b(req_ready_b),
    .req_opa_a(req_opa_a), .req_opb_a(req_opb_a),
    .req_opa_b(req_opa_b), .req_opb_b(req_opb_b),
    .req_cmd_a(req_cmd_a), .req_cmd_b(req_cmd_b),
    .rsp_valid_a(rsp_valid_a), .rsp_valid_b(rsp_valid_b),
    .rsp_ready_a(rsp_ready_a), .rsp_ready_b(rsp_ready_b),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
    .alu_result(alu_result), .alu_carryout(alu_carryout),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .zero_err(zero_err)
  );

  alu_request_arbiter #(.ALU_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(reset_n),
    .req_valid_a(req_valid_a), .req_valid_b(req_valid_b),
    .req_ready_a(req_ready_a3), .req_ready_b(req_ready_b3),
    .req_opa_a(req_opa_a), .req_opb_a(req_opb_a),
    .req_opa_b(req_opa_b), .req_opb_b(req_opb_b),
    .req_cmd_a(req_cmd_a), .req_cmd_b(req_cmd_b),
    .rsp_valid_a(rsp_valid_a3), .rsp_valid_b(rsp_valid_b3),
    .rsp_ready_a(rsp_ready_a), .rsp_ready_b(rsp_ready_b),
    .rsp_result(rsp_result3), .rsp_carryout(rsp_carryout3),
    .rsp_zero(rsp_zero3), .rsp_overflow(rsp_overflow3),
    .alu_opa(alu_opa3), .alu_opb(alu_opb3), .alu_cmd(alu_cmd3),
    .alu_result(alu_result3), .alu_carryout(alu_carryout3),
    .alu_zero(alu_zero3), .alu_overflow(alu_overflow3),
    .zero_err(zero_err3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic drive_a(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    req_valid_a = 1'b1; req_opa_a = a; req_opb_a = b; req_cmd_a = c;
  endtask

  task automatic drive_b(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    req_valid_b = 1'b1; req_opa_b = a; req_opb_b = b; req_cmd_b = c;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check_eq("rst_req_ready_a", 32'(req_ready_a), 32'd0);
    check_eq("rst_rsp_valid_a", 32'(rsp_valid_a), 32'd0);
    check_eq("rst_rsp_result",  rsp_result, 32'd0);
    check_eq("rst_alu_opa",     alu_opa, 32'd0);
    check_eq("rst_zero_err",    32'(zero_err), 32'd0);
    reset_n = 1'b1;
    tick();

    // ADD 5+7, latency 1
    drive_a(32'd5, 32'd7, C_ADD);
    #1 check_eq("t1_ready_a", 32'(req_ready_a), 32'd1);
    check_eq("t1_ready_b", 32'(req_ready_b), 32'd0);
    tick(); req_valid_a = 1'b0;
    check_eq("t1_wait_valid", 32'(rsp_valid_a), 32'd0);
    check_eq("t1_alu_opa", alu_opa, 32'd5);
    tick();
    check_eq("t1_rsp_valid_a", 32'(rsp_valid_a), 32'd1);
    check_eq("t1_rsp_valid_b", 32'(rsp_valid_b), 32'd0);
    check_eq("t1_result", rsp_result, 32'd12);
    check_eq("t1_zero", 32'(rsp_zero), 32'd0);
    check_eq("t1_carry", 32'(rsp_carryout), 32'd0);
    rsp_ready_a = 1'b1;
    tick(); rsp_ready_a = 1'b0;
    check_eq("t1_rsp_done", 32'(rsp_valid_a), 32'd0);

    // Both valid: A first, then B by round robin, then A again
    pulse_reset();
    rsp_ready_a = 1'b1; rsp_ready_b = 1'b1;
    drive_a(32'd9, 32'd9, C_SUB);
    drive_b(32'h0000_00F0, 32'h0000_000F, C_OR);
    #1 check_eq("t2_ready_a", 32'(req_ready_a), 32'd1);
    check_eq("t2_ready_b", 32'(req_ready_b), 32'd0);
    tick(); drive_a(32'h0000_FF00, 32'h0000_0FF0, C_XOR);
    check_eq("t2_wait_ready_a", 32'(req_ready_a), 32'd0);
    tick();
    check_eq("t2_a_valid", 32'(rsp_valid_a), 32'd1);
    check_eq("t2_a_result", rsp_result, 32'd0);
    check_eq("t2_a_zero", 32'(rsp_zero), 32'd1);
    tick();
    check_eq("t2_rr_ready_b", 32'(req_ready_b), 32'd1);
    check_eq("t2_rr_ready_a", 32'(req_ready_a), 32'd0);
    tick(); req_valid_b = 1'b0;
    tick();
    check_eq("t2_b_valid", 32'(rsp_valid_b), 32'd1);
    check_eq("t2_b_other", 32'(rsp_valid_a), 32'd0);
    check_eq("t2_b_result", rsp_result, 32'h0000_00FF);
    tick();
    check_eq("t2_rr_ready_a2", 32'(req_ready_a), 32'd1);
    tick(); req_valid_a = 1'b0;
    tick();
    check_eq("t2_a2_result", rsp_result, 32'h0000_F0F0);
    tick();
    rsp_ready_a = 1'b0; rsp_ready_b = 1'b0;

    // Back-pressure on B while A waits
    drive_b(32'h0000_00FF, 32'h0000_000F, C_AND);
    #1 check_eq("t3_ready_b", 32'(req_ready_b), 32'd1);
    tick(); req_valid_b = 1'b0;
    drive_a(32'd1, 32'd2, C_ADD);
    tick();
    check_eq("t3_b_valid", 32'(rsp_valid_b), 32'd1);
    check_eq("t3_b_result", rsp_result, 32'h0000_000F);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t3_hold_valid_b", 32'(rsp_valid_b), 32'd1);
      check_eq("t3_hold_result", rsp_result, 32'h0000_000F);
      check_eq("t3_hold_ready_a", 32'(req_ready_a), 32'd0);
    end
    rsp_ready_b = 1'b1;
    tick(); rsp_ready_b = 1'b0;
    check_eq("t3_b_done", 32'(rsp_valid_b), 32'd0);
    check_eq("t3_ready_a", 32'(req_ready_a), 32'd1);
    tick(); req_valid_a = 1'b0;
    check_eq("t3_a_opa", alu_opa, 32'd1);
    check_eq("t3_a_cmd", 32'(alu_cmd), 32'(C_ADD));
    rsp_ready_a = 1'b1;
    tick();
    check_eq("t3_a_result", rsp_result, 32'd3);
    tick();

    // Asynchronous reset in WAIT discards the operation
    drive_a(32'd4, 32'd4, C_ADD);
    #1 check_eq("t4_ready_a", 32'(req_ready_a), 32'd1);
    tick();
    reset_n = 1'b0;
    #1;
    check_eq("t4_rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
    check_eq("t4_rst_result", rsp_result, 32'd0);
    check_eq("t4_rst_alu_opa", alu_opa, 32'd0);
    check_eq("t4_rst_ready_a", 32'(req_ready_a), 32'd0);
    req_valid_a = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t4_no_rsp", 32'(rsp_valid_a), 32'd0);
    end
    drive_a(32'd2, 32'd2, C_ADD);
    drive_b(32'd3, 32'd3, C_ADD);
    #1 check_eq("t4_prio_a", 32'(req_ready_a), 32'd1);
    check_eq("t4_prio_b", 32'(req_ready_b), 32'd0);
    tick(); req_valid_a = 1'b0; req_valid_b = 1'b0;
    tick();
    check_eq("t4_valid", 32'(rsp_valid_a), 32'd1);
    check_eq("t4_result", rsp_result, 32'd4);
    tick();

    // Latency 3 instance: carry-out wraparound and operand stability
    pulse_reset();
    rsp_ready_a = 1'b0;
    drive_a(32'hFFFF_FFFF, 32'd1, C_ADD);
    #1 check_eq("t5_ready_a", 32'(req_ready_a3), 32'd1);
    tick(); req_valid_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq("t5_opa_stable", alu_opa3, 32'hFFFF_FFFF);
      check_eq("t5_opb_stable", alu_opb3, 32'd1);
      check_eq("t5_no_valid", 32'(rsp_valid_a3), 32'd0);
      tick();
    end
    check_eq("t5_valid", 32'(rsp_valid_a3), 32'd1);
    check_eq("t5_result", rsp_result3, 32'd0);
    check_eq("t5_carry", 32'(rsp_carryout3), 32'd1);
    check_eq("t5_zero", 32'(rsp_zero3), 32'd1);
    rsp_ready_a = 1'b1;
    tick();
    check_eq("t5_done", 32'(rsp_valid_a3), 32'd0);

    // Zero-flag checker with an ALU that misreports zero
    pulse_reset();
    force_bad = 1'b1;
    drive_a(32'd5, 32'd5, C_SUB);
    tick(); req_valid_a = 1'b0;
    tick();
    check_eq("t6_result", rsp_result, 32'd0);
    check_eq("t6_rsp_zero", 32'(rsp_zero), 32'd0);
    check_eq("t6_zero_err", 32'(zero_err), 32'(ZERR_EXP));
    tick(); tick(); tick();
    check_eq("t6_zero_err_sticky", 32'(zero_err), 32'(ZERR_EXP));
    force_bad = 1'b0;
    pulse_reset();
    check_eq("t6_zero_err_rst", 32'(zero_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
